pipe_ctrl_fsm: RTL

Parametrised, stateful successor to the Y86 pipeline hazard controller. It produces per-stage stall and bubble controls from decode, execute, memory and writeback state. Beyond the classic load-use, ret and mispredict cases, it adds a data-memory wait handshake with timeout, an exception drain/halt FSM and a saturating stall-cycle counter. It sits beside the F/D/E/M/W pipeline registers in the top-level pipelined core.

---
 rtl/pipe_ctrl_fsm.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline hazard controller: per-stage stall/bubble controls with a dmem wait/timeout,
// exception drain/halt FSM and an optional stall-cycle counter (PIPE_PERF_CNT_EN).
module pipe_ctrl_fsm #(
   parameter int REG_W       = 4,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       D_icode,
   input  logic [REG_W-1:0] d_srcA,
   input  logic [REG_W-1:0] d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [REG_W-1:0] E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_stall,
   output logic             E_bubble,
   output logic             M_stall,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_CC,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [REG_W-1:0] RNONE = '1;
   localparam logic [3:0] I_MRMOVQ = 4'd5, I_POPQ = 4'd11, I_RET = 4'd9,
                          I_JXX = 4'd7, I_OPQ = 4'd6;
   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TMO = WC_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_nxt;

   function automatic logic bad(input logic [2:0] s);
      return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
   endfunction

   logic lu, ret, mp, mw_raw, m_bad, w_bad, exc, mw, timeout;

   assign lu     = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign ret    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign mp     = (E_icode == I_JXX) && !e_Cnd;
   assign mw_raw = dmem_req && !dmem_ready;
   assign m_bad  = bad(m_stat);
   assign w_bad  = bad(W_stat);
   assign exc    = m_bad || w_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      mw        = 1'b0;
      timeout   = 1'b0;
      F_stall   = 1'b0;
      D_stall   = 1'b0;
      D_bubble  = 1'b0;
      E_stall   = 1'b0;
      E_bubble  = 1'b0;
      M_stall   = 1'b0;
      M_bubble  = 1'b0;
      W_stall   = 1'b0;
      set_CC    = 1'b0;

      case (state)
         RUN: begin
            // a faulting M stage takes precedence over a pending memory wait
            mw = mw_raw && !m_bad;
            if (m_bad) begin
               state_nxt = DRAIN;
            end else if (mw_raw && !exc) begin
               state_nxt = MEMWAIT;
               wait_nxt  = WC_W'(1);
            end
         end
         MEMWAIT: begin
            // the access is outstanding whether or not dmem_req is still asserted
            mw = !dmem_ready;
            if (dmem_ready) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (wait_cnt == TMO) begin
               timeout   = 1'b1;
               state_nxt = DRAIN;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (w_bad) state_nxt = HALT;
         end
         default: ;
      endcase

      if (state == HALT) begin
         F_stall = 1'b1;
         D_stall = 1'b1;
         E_stall = 1'b1;
         M_stall = 1'b1;
         W_stall = 1'b1;
      end else begin
         F_stall  = lu || ret || mw;
         D_stall  = lu || mw;
         D_bubble = !mw && (mp || (!lu && ret));
         E_stall  = mw;
         E_bubble = !mw && (mp || lu);
         M_stall  = mw;
         M_bubble = exc || timeout || (state == DRAIN);
         W_stall  = w_bad;
         set_CC   = (E_icode == I_OPQ) && !exc && !mw && (state != DRAIN);
      end

      if (!rst_n) begin
         F_stall  = 1'b0;
         D_stall  = 1'b0;
         D_bubble = 1'b1;
         E_stall  = 1'b0;
         E_bubble = 1'b1;
         M_stall  = 1'b0;
         M_bubble = 1'b1;
         W_stall  = 1'b0;
         set_CC   = 1'b0;
      end
   end

   assign ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           stall_q <= '0;
      else if (F_stall && (stall_q != '1))  stall_q <= stall_q + 1'b1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
